// File: rtl/dispatch_pkg.sv
// Shared constants and types for the dual dispatch slice: opcode encodings,
// buffer FSM states and reservation-station classes.
package dispatch_pkg;

    localparam logic [6:0]  OPC_LOAD    = 7'b0000011;
    localparam logic [6:0]  OPC_STORE   = 7'b0100011;
    localparam logic [31:0] BUBBLE_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } disp_state_e;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_BUBBLE
    } station_cls_e;

endpackage

// File: rtl/instr_classify.sv
// Combinational station classifier: loads/stores go to MEM, the all-zero word
// is a bubble, everything else goes to ALU.
module instr_classify
    import dispatch_pkg::*;
(
    input  logic [31:0]  instr,
    output station_cls_e cls
);

    always_comb begin
        cls = CLS_ALU;
        if (instr == BUBBLE_WORD) begin
            cls = CLS_BUBBLE;
        end else if (instr[6:0] == OPC_LOAD || instr[6:0] == OPC_STORE) begin
            cls = CLS_MEM;
        end
    end

endmodule

// File: rtl/dual_dispatch.sv
// Two-slot in-order dispatch buffer feeding ALU/MEM reservation stations.
// Define DUAL_DISPATCH_STATS_EN to add the saturating stall_cycles counter.
module dual_dispatch
    import dispatch_pkg::*;
#(
    parameter int RS_FREE_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iq_valid,
    input  logic [31:0]          instr1,
    input  logic [31:0]          instr2,
    input  logic                 instr2_valid,
    output logic                 dispatch_1_ready,
    output logic                 dispatch_2_ready,
    input  logic [RS_FREE_W-1:0] rs_alu_free,
    input  logic [RS_FREE_W-1:0] rs_mem_free,
    output logic                 issue0_valid,
    output logic                 issue1_valid,
    output logic [31:0]          issue0_instr,
    output logic [31:0]          issue1_instr,
    output logic                 issue0_is_mem,
    output logic                 issue1_is_mem
`ifdef DUAL_DISPATCH_STATS_EN
    ,
    output logic [15:0]          stall_cycles
`endif
);

    localparam logic [RS_FREE_W:0] FREE_TWO = (RS_FREE_W + 1)'(2);

    disp_state_e          state_q, state_d;
    logic [31:0]          slot0_q, slot0_d;
    logic [31:0]          slot1_q, slot1_d;
    logic                 ready_q;
    station_cls_e         cls0, cls1;
    logic                 slot0_vld, slot1_vld;
    logic                 leave0, leave1, load;
    logic                 same_station;
    logic [RS_FREE_W-1:0] free0, free1;

    instr_classify u_cls0 (.instr(slot0_q), .cls(cls0));
    instr_classify u_cls1 (.instr(slot1_q), .cls(cls1));

    assign slot0_vld = (state_q != EMPTY);
    assign slot1_vld = (state_q == TWO);
    assign load      = iq_valid && ready_q;

    // Slot1 may only leave alongside slot0; a shared station must then hold both.
    always_comb begin
        free0        = (cls0 == CLS_MEM) ? rs_mem_free : rs_alu_free;
        free1        = (cls1 == CLS_MEM) ? rs_mem_free : rs_alu_free;
        same_station = (cls0 != CLS_BUBBLE) && (cls0 == cls1);
        leave0       = slot0_vld && ((cls0 == CLS_BUBBLE) || (free0 != '0));
        leave1       = slot1_vld && leave0 &&
                       ((cls1 == CLS_BUBBLE) ||
                        (same_station ? ({1'b0, free1} >= FREE_TWO) : (free1 != '0)));
    end

    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (state_q)
            EMPTY: begin
                if (load) begin
                    slot0_d = instr1;
                    slot1_d = instr2_valid ? instr2 : '0;
                    state_d = instr2_valid ? TWO : ONE;
                end
            end
            ONE: begin
                if (leave0) begin
                    slot0_d = '0;
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (leave0 && leave1) begin
                    slot0_d = '0;
                    slot1_d = '0;
                    state_d = EMPTY;
                end else if (leave0) begin
                    slot0_d = slot1_q;
                    slot1_d = '0;
                    state_d = ONE;
                end
            end
            default: begin
                slot0_d = '0;
                slot1_d = '0;
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            ready_q <= (state_d == EMPTY);
        end
    end

    assign dispatch_1_ready = ready_q;
    assign dispatch_2_ready = ready_q;

    assign issue0_valid  = leave0 && (cls0 != CLS_BUBBLE);
    assign issue1_valid  = leave1 && (cls1 != CLS_BUBBLE);
    assign issue0_instr  = issue0_valid ? slot0_q : '0;
    assign issue1_instr  = issue1_valid ? slot1_q : '0;
    assign issue0_is_mem = issue0_valid && (cls0 == CLS_MEM);
    assign issue1_is_mem = issue1_valid && (cls1 == CLS_MEM);

`ifdef DUAL_DISPATCH_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (slot0_vld && !leave0 && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
